updi_block_writer: RTL

- Downstream stage of program_decoder. It accepts one decoded block (length, address, type, data array) and serialises it into a UPDI write sequence: ST ptr, REPEAT, then ST *(ptr++) with per-byte ACK checking.
- It drives a byte-stream TX interface toward the UPDI PHY/UART.
- It consumes target response bytes from the RX interface.

---
 rtl/updi_pkg.sv | 35 +++
 rtl/updi_ack_waiter.sv | 54 +++++
 rtl/updi_block_writer.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/updi_pkg.sv
// rtl/updi_pkg.sv - UPDI opcode constants and block writer state encoding
//
// Purpose: shared definitions for the UPDI block writer and its ACK waiter.
// Contents:
//   UPDI_* opcode/handshake byte constants
//   BLOCK_TYPE_DATA block type code that triggers a real write
//   state_e         block writer FSM states
package updi_pkg;

  localparam logic [7:0] UPDI_SYNCH        = 8'h55;
  localparam logic [7:0] UPDI_ACK          = 8'h40;
  localparam logic [7:0] UPDI_ST_PTR16     = 8'h69;
  localparam logic [7:0] UPDI_REPEAT_B     = 8'hA0;
  localparam logic [7:0] UPDI_ST_PTR_INC_B = 8'h64;
  localparam logic [7:0] BLOCK_TYPE_DATA   = 8'h00;

  typedef enum logic [3:0] {
    S_IDLE,
    S_PTR_SYNC,
    S_PTR_OP,
    S_PTR_AL,
    S_PTR_AH,
    S_PTR_ACK,
    S_RPT_SYNC,
    S_RPT_OP,
    S_RPT_CNT,
    S_ST_SYNC,
    S_ST_OP,
    S_DATA,
    S_DATA_ACK,
    S_DONE,
    S_ERR
  } state_e;

endpackage

// File: rtl/updi_ack_waiter.sv
// rtl/updi_ack_waiter.sv - timeout counter and ACK/NACK compare for UPDI wait states
//
// Purpose: while enabled, counts cycles and classifies the target reply.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   en_i            high while the writer sits in a wait state
//   rx_valid_i      one-cycle strobe for rx_data_i
//   rx_data_i       byte received from the target
//   ok_o            ACK byte received this cycle
//   fail_o          wrong byte received, or timeout reached without a reply
module updi_ack_waiter
  import updi_pkg::*;
#(
  parameter int ACK_TIMEOUT = 4096
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  input  logic       rx_valid_i,
  input  logic [7:0] rx_data_i,
  output logic       ok_o,
  output logic       fail_o
);

  localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timed_out;

  // Counter is held at zero outside a wait state so every wait starts fresh;
  // wrap at the last value is harmless because fail_o forces an exit there.
  always_comb begin
    cnt_d = '0;
    if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign timed_out = (cnt_q == CNT_LAST);

  // A reply in the same cycle as the timeout wins over the timeout.
  assign ok_o   = en_i && rx_valid_i && (rx_data_i == UPDI_ACK);
  assign fail_o = en_i && (rx_valid_i ? (rx_data_i != UPDI_ACK) : timed_out);

endmodule

// File: rtl/updi_block_writer.sv
// rtl/updi_block_writer.sv - serialise one decoded block into a UPDI ST ptr / REPEAT / ST *ptr++ sequence
//
// Purpose: accepts a block (length, address, type, payload) and emits the UPDI
// byte stream toward the PHY, checking the target ACK after the pointer store
// and after every data byte.
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   start_i              one-cycle request, sampled only while ready_o=1
//   block_length_i       data byte count
//   block_address_i      target start address
//   block_type_i         0x00 = data write, anything else = no-op
//   block_data_i         payload array
//   ready_o              high in IDLE only
//   done_o               one-cycle pulse at the end of a block (success or error)
//   error_o              sticky error flag, cleared by the next accepted start
//   tx_data_o/valid_o    byte toward the PHY, registered
//   tx_ready_i           PHY accepts when tx_valid_o && tx_ready_i
//   rx_data_i/valid_i    byte from the target, one-cycle strobe
module updi_block_writer
  import updi_pkg::*;
#(
  parameter int DATA_BLOCK_MAX_SIZE = 16,
  parameter int ACK_TIMEOUT         = 4096
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [7:0]  block_length_i,
  input  logic [15:0] block_address_i,
  input  logic [7:0]  block_type_i,
  input  logic [7:0]  block_data_i [DATA_BLOCK_MAX_SIZE],
  output logic        ready_o,
  output logic        done_o,
  output logic        error_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i
);

  localparam int IDX_W = (DATA_BLOCK_MAX_SIZE > 1) ? $clog2(DATA_BLOCK_MAX_SIZE) : 1;
  localparam logic [7:0] MAX_LEN = 8'(DATA_BLOCK_MAX_SIZE);

  state_e           state_q, state_d;
  logic [7:0]       len_q, len_d;
  logic [15:0]      addr_q, addr_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             error_q, error_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             tx_valid_q, tx_valid_d;
  logic [7:0]       data_q [DATA_BLOCK_MAX_SIZE];

  logic             accept;
  logic             wait_en;
  logic             ack_ok, ack_fail;
  logic             in_byte;
  logic [7:0]       tx_byte;
  state_e           byte_next;
  logic             last_byte;

  updi_ack_waiter #(
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_ack_waiter (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .en_i       (wait_en),
    .rx_valid_i (rx_valid_i),
    .rx_data_i  (rx_data_i),
    .ok_o       (ack_ok),
    .fail_o     (ack_fail)
  );

  assign last_byte = (8'(idx_q) == (len_q - 8'd1));

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    addr_d     = addr_q;
    idx_d      = idx_q;
    error_d    = error_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    accept     = 1'b0;
    wait_en    = 1'b0;
    in_byte    = 1'b0;
    tx_byte    = 8'h00;
    byte_next  = state_q;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          accept  = 1'b1;
          error_d = 1'b0;
          len_d   = block_length_i;
          addr_d  = block_address_i;
          idx_d   = '0;
          if ((block_type_i != BLOCK_TYPE_DATA) || (block_length_i == 8'd0)) begin
            state_d = S_DONE;
          end else if (block_length_i > MAX_LEN) begin
            state_d = S_ERR;
          end else begin
            state_d = S_PTR_SYNC;
          end
        end
      end
      S_PTR_SYNC: begin in_byte = 1'b1; tx_byte = UPDI_SYNCH;        byte_next = S_PTR_OP;   end
      S_PTR_OP:   begin in_byte = 1'b1; tx_byte = UPDI_ST_PTR16;     byte_next = S_PTR_AL;   end
      S_PTR_AL:   begin in_byte = 1'b1; tx_byte = addr_q[7:0];       byte_next = S_PTR_AH;   end
      S_PTR_AH:   begin in_byte = 1'b1; tx_byte = addr_q[15:8];      byte_next = S_PTR_ACK;  end
      S_PTR_ACK: begin
        wait_en = 1'b1;
        if (ack_fail) begin
          state_d = S_ERR;
        end else if (ack_ok) begin
          state_d = S_RPT_SYNC;
        end
      end
      S_RPT_SYNC: begin in_byte = 1'b1; tx_byte = UPDI_SYNCH;        byte_next = S_RPT_OP;   end
      S_RPT_OP:   begin in_byte = 1'b1; tx_byte = UPDI_REPEAT_B;     byte_next = S_RPT_CNT;  end
      // REPEAT takes the count minus one, so a single byte sends 0x00.
      S_RPT_CNT:  begin in_byte = 1'b1; tx_byte = len_q - 8'd1;      byte_next = S_ST_SYNC;  end
      S_ST_SYNC:  begin in_byte = 1'b1; tx_byte = UPDI_SYNCH;        byte_next = S_ST_OP;    end
      S_ST_OP:    begin in_byte = 1'b1; tx_byte = UPDI_ST_PTR_INC_B; byte_next = S_DATA;     end
      S_DATA:     begin in_byte = 1'b1; tx_byte = data_q[idx_q];     byte_next = S_DATA_ACK; end
      S_DATA_ACK: begin
        wait_en = 1'b1;
        if (ack_fail) begin
          state_d = S_ERR;
        end else if (ack_ok) begin
          // idx is not advanced past the last byte, so it never overflows
          // even when the block fills the whole array.
          if (last_byte) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_DATA;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Shared byte handshake: first cycle in a byte state loads the register,
    // the byte then holds until accepted, and valid drops for one cycle
    // before the next state loads its byte.
    if (in_byte) begin
      if (tx_valid_q) begin
        if (tx_ready_i) begin
          tx_valid_d = 1'b0;
          state_d    = byte_next;
        end
      end else begin
        tx_valid_d = 1'b1;
        tx_data_d  = tx_byte;
      end
    end

    if (state_d == S_ERR) begin
      error_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      len_q      <= 8'h00;
      addr_q     <= 16'h0000;
      idx_q      <= '0;
      error_q    <= 1'b0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      addr_q     <= addr_d;
      idx_q      <= idx_d;
      error_q    <= error_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
    end
  end

  // Payload storage needs no reset: it is only read after a fresh capture.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      data_q <= block_data_i;
    end
  end

  assign ready_o    = (state_q == S_IDLE);
  assign done_o     = (state_q == S_DONE) || (state_q == S_ERR);
  assign error_o    = error_q;
  assign tx_data_o  = tx_data_q;
  assign tx_valid_o = tx_valid_q;

endmodule
